// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage driving PC controls, an imem req/ack bus and a one-entry decode buffer
module fetch_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_inc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_in,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              fetch_err
);
  typedef enum logic [1:0] {ISSUE, WAIT, FULL, HALT} state_t;
  state_t state, state_n;
  logic squash, ack, fire, timeout;
  logic [15:0] cnt;
  always_comb begin
    ack = state == WAIT && imem_ack;
    fire = inst_valid && inst_ready && !jump_valid;
    timeout = state == WAIT && !imem_ack && cnt == 16'(TIMEOUT_CYCLES - 1);
    state_n = state;
    if (reset) state_n = ISSUE;
    else if (state == ISSUE) state_n = WAIT;
    else if (ack) state_n = (squash || jump_valid) ? ISSUE : FULL;
    else if (timeout) state_n = HALT;
    else if (state == FULL && (fire || jump_valid)) state_n = ISSUE;
    pc_load = !reset && jump_valid && state != HALT;
    pc_inc = !reset && ack && !squash && !jump_valid;
    pc_in = pc_load ? jump_target : '0;
  end
  always_ff @(posedge clock) begin
    state <= state_n;
    imem_req <= state_n == WAIT;
    inst_valid <= state_n == FULL;
    cnt <= (state == WAIT && state_n == WAIT) ? cnt + 16'd1 : '0;
    if (reset) begin
      squash <= 1'b0;
      imem_addr <= '0;
      inst_data <= '0;
      inst_pc <= '0;
      fetch_err <= 1'b0;
    end else begin
      // a jump seen while the request is in flight poisons the returning data
      if (state == ISSUE) begin
        imem_addr <= pc_addr;
        squash <= jump_valid;
      end
      if (ack) squash <= 1'b0;
      else if (state == WAIT && jump_valid) squash <= 1'b1;
      if (pc_inc) begin
        inst_data <= imem_rdata;
        inst_pc <= imem_addr;
      end
      if (timeout) fetch_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with a PC register model and a programmable-latency instruction memory
module tb_fetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [15:0] pc_addr, pc_in, imem_addr, imem_rdata, inst_data, inst_pc;
  logic [15:0] jump_target = 16'h0;
  logic [15:0] pc_force_val = 16'h0;
  logic pc_inc, pc_load, imem_req, imem_ack, inst_valid, fetch_err;
  logic jump_valid = 1'b0;
  logic inst_ready = 1'b1;
  logic pc_force = 1'b1;
  logic mem_dead = 1'b0;
  logic ack_force = 1'b0;
  logic ok;
  int mem_delay = 0;
  int wcnt = 0;
  int checks = 0;
  int failures = 0;

  fetch_unit #(.DATA_W(16), .ADDR_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .pc_addr(pc_addr), .pc_inc(pc_inc), .pc_load(pc_load),
    .pc_in(pc_in), .jump_valid(jump_valid), .jump_target(jump_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pc_force) pc_addr <= pc_force_val;
    else if (pc_load) pc_addr <= pc_in;
    else if (pc_inc) pc_addr <= pc_addr + 16'd1;
    wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;
  end

  assign imem_ack = ack_force || (imem_req && !mem_dead && wcnt == mem_delay);
  assign imem_rdata = 16'h1000 + imem_addr;

  task automatic wait_req(input logic [15:0] a, output logic found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      found = imem_req === 1'b1 && imem_addr === a;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; pc_force = 1'b1; pc_force_val = 16'h0;
    jump_valid = 1'b1; jump_target = 16'h1234;
    repeat (2) @(negedge clock);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b want=0", imem_req); end
    checks++; if (imem_addr !== 16'h0) begin failures++; $display("FAIL rst_addr got=%h want=0000", imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", inst_valid); end
    checks++; if (inst_data !== 16'h0 || inst_pc !== 16'h0) begin failures++; $display("FAIL rst_inst got=%h/%h want=0000/0000", inst_data, inst_pc); end
    checks++; if (fetch_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b want=0", fetch_err); end
    checks++; if (pc_load !== 1'b0 || pc_in !== 16'h0 || pc_inc !== 1'b0) begin failures++; $display("FAIL rst_pcctl got=%b/%h/%b want=0/0000/0", pc_load, pc_in, pc_inc); end
    jump_valid = 1'b0; reset = 1'b0; pc_force = 1'b0;
  endtask

  task automatic test_stream;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      checks++; if (inst_valid !== (c % 3 == 2)) begin failures++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, inst_valid, c % 3 == 2); end
      checks++; if (pc_inc !== (c % 3 == 1)) begin failures++; $display("FAIL stream_inc c=%0d got=%b want=%b", c, pc_inc, c % 3 == 1); end
      if (c % 3 == 1) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'((c - 1) / 3)) begin failures++; $display("FAIL stream_req c=%0d got=%b/%h want=1/%h", c, imem_req, imem_addr, 16'((c - 1) / 3)); end
      end
      if (c % 3 == 2) begin
        checks++; if (inst_data !== 16'(16'h1000 + (c - 2) / 3) || inst_pc !== 16'((c - 2) / 3)) begin failures++; $display("FAIL stream_inst c=%0d got=%h/%h want=%h/%h", c, inst_data, inst_pc, 16'(16'h1000 + (c - 2) / 3), 16'((c - 2) / 3)); end
      end
    end
  endtask

  task automatic test_stall;
    wait_req(16'h5, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_reach got=timeout want=fetch of 0005"); end
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++; if (inst_valid !== 1'b1 || inst_data !== 16'h1005 || inst_pc !== 16'h5) begin failures++; $display("FAIL stall_hold i=%0d got=%b/%h/%h want=1/1005/0005", i, inst_valid, inst_data, inst_pc); end
      checks++; if (imem_req !== 1'b0 || pc_inc !== 1'b0) begin failures++; $display("FAIL stall_bus i=%0d got=%b/%b want=0/0", i, imem_req, pc_inc); end
    end
    inst_ready = 1'b1;
    @(negedge clock);
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL stall_release got=%b/%b want=0/0", inst_valid, imem_req); end
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h6) begin failures++; $display("FAIL stall_next got=%b/%h want=1/0006", imem_req, imem_addr); end
  endtask

  task automatic test_jump_wait;
    mem_delay = 4;
    wait_req(16'h7, ok);
    checks++; if (!ok) begin failures++; $display("FAIL jw_reach got=timeout want=fetch of 0007"); end
    @(negedge clock);
    jump_valid = 1'b1; jump_target = 16'h0200;
    #1;
    checks++; if (pc_load !== 1'b1 || pc_in !== 16'h0200 || pc_inc !== 1'b0) begin failures++; $display("FAIL jw_load got=%b/%h/%b want=1/0200/0", pc_load, pc_in, pc_inc); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      jump_valid = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h7) begin failures++; $display("FAIL jw_hold i=%0d got=%b/%h want=1/0007", i, imem_req, imem_addr); end
    end
    checks++; if (imem_ack !== 1'b1 || pc_inc !== 1'b0) begin failures++; $display("FAIL jw_drop got ack=%b inc=%b want ack=1 inc=0", imem_ack, pc_inc); end
    @(negedge clock);
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL jw_discard got=%b/%b want=0/0", inst_valid, imem_req); end
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin failures++; $display("FAIL jw_target got=%b/%h want=1/0200", imem_req, imem_addr); end
  endtask

  task automatic test_jump_full;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ok = inst_valid === 1'b1;
    end
    checks++; if (!ok || inst_data !== 16'h1200 || inst_pc !== 16'h0200) begin failures++; $display("FAIL jf_full got=%b/%h/%h want=1/1200/0200", ok, inst_data, inst_pc); end
    jump_valid = 1'b1; jump_target = 16'h0040;
    #1;
    checks++; if (pc_load !== 1'b1 || pc_in !== 16'h0040) begin failures++; $display("FAIL jf_load got=%b/%h want=1/0040", pc_load, pc_in); end
    @(negedge clock);
    jump_valid = 1'b0;
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL jf_flush got=%b want=0", inst_valid); end
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin failures++; $display("FAIL jf_next got=%b/%h want=1/0040", imem_req, imem_addr); end
  endtask

  task automatic test_timeout;
    mem_dead = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin failures++; $display("FAIL to_wait i=%0d got=%b/%b want=1/0", i, imem_req, fetch_err); end
    end
    @(negedge clock);
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL to_halt got=%b/%b want=1/0", fetch_err, imem_req); end
    jump_valid = 1'b1; jump_target = 16'h1234;
    #1;
    checks++; if (pc_load !== 1'b0 || pc_in !== 16'h0) begin failures++; $display("FAIL to_nojump got=%b/%h want=0/0000", pc_load, pc_in); end
    @(negedge clock);
    jump_valid = 1'b0;
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin failures++; $display("FAIL to_sticky got=%b/%b/%b want=1/0/0", fetch_err, imem_req, inst_valid); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL to_clear got=%b/%b want=0/0", fetch_err, imem_req); end
    reset = 1'b0; mem_dead = 1'b0; mem_delay = 0;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin failures++; $display("FAIL to_restart got=%b/%h want=1/0040", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_and_reset;
    reset = 1'b1; pc_force = 1'b1; pc_force_val = 16'hFFFF;
    @(negedge clock);
    reset = 1'b0; pc_force = 1'b0;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'hFFFF || pc_inc !== 1'b1) begin failures++; $display("FAIL wrap_fetch got=%b/%h/%b want=1/ffff/1", imem_req, imem_addr, pc_inc); end
    @(negedge clock);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'hFFFF || inst_data !== 16'h0FFF) begin failures++; $display("FAIL wrap_inst got=%b/%h/%h want=1/ffff/0fff", inst_valid, inst_pc, inst_data); end
    checks++; if (pc_addr !== 16'h0) begin failures++; $display("FAIL wrap_pc got=%h want=0000", pc_addr); end
    @(negedge clock);
    mem_dead = 1'b1;
    @(negedge clock);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin failures++; $display("FAIL wrap_next got=%b/%h want=1/0000", imem_req, imem_addr); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rw_req got=%b want=0", imem_req); end
    reset = 1'b0; ack_force = 1'b1;
    #1;
    checks++; if (pc_inc !== 1'b0) begin failures++; $display("FAIL rw_lateack_inc got=%b want=0", pc_inc); end
    @(negedge clock);
    ack_force = 1'b0;
    checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0) begin failures++; $display("FAIL rw_lateack got=%b/%b/%h want=0/1/0000", inst_valid, imem_req, imem_addr); end
    @(negedge clock);
    checks++; if (inst_valid !== 1'b0 || fetch_err !== 1'b0) begin failures++; $display("FAIL rw_settle got=%b/%b want=0/0", inst_valid, fetch_err); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_jump_wait;
    test_jump_full;
    test_timeout;
    test_wrap_and_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the 16-bit program counter.
- Consumes the PC value, reads instruction memory over a req/ack bus, and buffers one instruction for decode behind a valid/ready handshake.
- Drives the PC's `inc`, `load` and `in` controls: advances the PC on each successful fetch and redirects it on jumps from execute.
- Detects a hung memory through an ack timeout.

Parameters:
- DATA_W, 16, instruction width
- ADDR_W, 16, address / PC width
- TIMEOUT_CYCLES, 255, maximum WAIT cycles without ack before error; range 1..65535

Ports:
- clock, input, 1, clock; all state updates on rising edge
- reset, input, 1, synchronous, active-high
- pc_addr, input, ADDR_W, current PC value (PC register output)
- pc_inc, output, 1, PC increment request
- pc_load, output, 1, PC load request
- pc_in, output, ADDR_W, PC load value
- jump_valid, input, 1, redirect request from execute
- jump_target, input, ADDR_W, redirect address
- imem_req, output, 1, memory read request
- imem_addr, output, ADDR_W, memory read address
- imem_ack, input, 1, read data valid this cycle
- imem_rdata, input, DATA_W, read data
- inst_valid, output, 1, buffered instruction available
- inst_data, output, DATA_W, buffered instruction
- inst_pc, output, ADDR_W, address the buffered instruction was fetched from
- inst_ready, input, 1, decode accepts
- fetch_err, output, 1, sticky timeout flag

Behaviour:

Reset:
- reset is synchronous, active-high; clock is clock.
- While reset is sampled high: state goes to ISSUE; squash and timeout counter clear.
- Registered outputs reset to 0: imem_req, imem_addr, inst_valid, inst_data, inst_pc, fetch_err.
- Combinational outputs are forced to 0 while reset is high: pc_inc, pc_load, pc_in.
- Reset mid-fetch abandons the outstanding request with no further action; a late ack after reset is ignored in ISSUE.

States:
- ISSUE: latch imem_addr <= pc_addr; go to WAIT.
- WAIT: imem_req=1; imem_addr held stable until ack; timeout counter increments each WAIT cycle without ack.
  - ack with squash=0 and jump_valid=0: inst_data <= imem_rdata, inst_pc <= imem_addr, inst_valid <= 1; pc_inc=1 this cycle; go to FULL.
  - ack with squash=1 or jump_valid=1: data discarded, pc_inc=0, squash cleared, go to ISSUE.
  - jump_valid without ack: squash <= 1; remain in WAIT, because the bus rule requires req held until ack.
  - counter reaches TIMEOUT_CYCLES: fetch_err <= 1, go to HALT.
  - Counter clears on leaving WAIT.
- FULL: inst_valid=1; imem_req=0.
  - fire = inst_valid & inst_ready & ~jump_valid.
  - fire: inst_valid <= 0; go to ISSUE.
  - jump_valid: buffer flushed (inst_valid <= 0) regardless of inst_ready; no transfer counts; go to ISSUE.
- HALT: imem_req=0; inst_valid=0; jump_valid ignored (pc_load=0); exited only by reset.

PC control (all combinational):
- pc_load = jump_valid & state≠HALT & ~reset.
- pc_in = jump_target when pc_load=1, else 0.
- pc_inc only as defined in WAIT; never asserted together with pc_load.
- The PC register updates on the next edge, so ISSUE always sees the post-increment or post-jump PC.

Imem bus:
- imem_req is registered from next-state, so it is high exactly during WAIT cycles.
- imem_ack outside WAIT is ignored.

Throughput and latency:
- Zero-wait memory (ack in the first WAIT cycle) with inst_ready held high: one instruction every 3 cycles.
- ISSUE -> WAIT -> FULL, then handshake.

Wrap-around:
- imem_addr and inst_pc are plain copies; the PC wraps 0xFFFF -> 0x0000 externally.
- The fetch from 0xFFFF proceeds normally, and the next fetch is from 0x0000.

Test Plan:
1. Reset, PC model starts at 0, memory returns 0x1000+addr with ack in the first WAIT cycle, inst_ready=1 -> instructions 0x1000, 0x1001, 0x1002 with inst_pc 0, 1, 2; inst_valid high once every 3 cycles; one pc_inc pulse per instruction.
2. inst_ready=0 for 10 cycles while FULL holding 0x1005 -> inst_valid, inst_data and inst_pc stable; imem_req=0; no pc_inc. Release ready -> next fetch from address 6.
3. Memory ack delayed 4 cycles; jump_valid pulsed with jump_target=0x0200 in the 2nd WAIT cycle -> pc_load=1 and pc_in=0x0200 that cycle; imem_addr unchanged until ack; acked data dropped, no pc_inc; next imem_addr=0x0200.
4. FULL with inst_ready=1 and jump_valid=1 in the same cycle (target 0x0040) -> no transfer; inst_valid=0 next cycle; next fetch address 0x0040.
5. TIMEOUT_CYCLES=8, memory never acks -> fetch_err=1 after 8 WAIT cycles; imem_req falls; later jump_valid gives pc_load=0. Reset clears fetch_err and restarts fetching at the PC value.
6. PC at 0xFFFF -> instruction fetched with inst_pc=0xFFFF, then next fetch at 0x0000. Reset asserted during WAIT -> imem_req=0 next cycle, and a late ack is ignored.
